// File: rtl/ppt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppt_pkg
//  Brief    : Shared types and constants for the PPT burst scheduler slice.
//  Revision : 1.0  initial release
// ============================================================================
package ppt_pkg;

    localparam int PULSE_W = 14;

    // Reset config shared with pulse_generator
    localparam logic [PULSE_W-1:0] GEN_PERIOD_RST = 14'd128;
    localparam logic [PULSE_W-1:0] GEN_WIDTH_RST  = 14'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_FIRE     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_e;

    function automatic logic cfg_bad(input logic [PULSE_W-1:0] period,
                                     input logic [PULSE_W-1:0] width);
        return (width == '0) || (width >= period);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppt_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppt_burst_scheduler_if
//  Brief    : Burst command channel between host registers and the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface ppt_burst_scheduler_if
    import ppt_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PULSE_W-1:0] cfg_period;
    logic [PULSE_W-1:0] cfg_width;
    logic [CNT_W-1:0]   cfg_count;
    logic [CNT_W-1:0]   cfg_cooldown;

    modport master (
        output cfg_valid, cfg_period, cfg_width, cfg_count, cfg_cooldown,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_width, cfg_count, cfg_cooldown,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/ppt_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ppt_edge_counter
//  Brief    : Counts generator pulse rising edges during FIRE and runs the
//             missing-pulse watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module ppt_edge_counter
    import ppt_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WDOG_MARGIN = 4
)
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               clear,
    input  wire logic               fire,
    input  wire logic               gen_pulse,
    input  wire logic [PULSE_W-1:0] period,
    output logic                    rise,
    output logic                    wd_timeout,
    output logic [CNT_W-1:0]        pulses_fired
);

    logic               pulse_q;
    logic [PULSE_W:0]   wd_cnt;
    logic [PULSE_W:0]   wd_limit;

    assign rise       = fire & gen_pulse & ~pulse_q;
    // Compare one bit wider than the period so the margin cannot wrap
    assign wd_limit   = {1'b0, period} + (PULSE_W+1)'(WDOG_MARGIN);
    assign wd_timeout = fire & (wd_cnt >= wd_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q      <= 1'b0;
            pulses_fired <= '0;
            wd_cnt       <= '0;
        end else begin
            pulse_q <= gen_pulse;

            if (clear)
                pulses_fired <= '0;
            else if (rise && (pulses_fired != '1))
                pulses_fired <= pulses_fired + CNT_W'(1);

            if (!fire || rise)
                wd_cnt <= '0;
            else if (wd_cnt != '1)
                wd_cnt <= wd_cnt + (PULSE_W+1)'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppt_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ppt_burst_scheduler
//  Brief    : Sequences pulse_generator through N-pulse bursts with cooldown,
//             abort, fault lockout and missing-pulse watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module ppt_burst_scheduler
    import ppt_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LOAD_CYC    = 2,
    parameter int WDOG_MARGIN = 4
)
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    ppt_burst_scheduler_if.slave    cfg,
    input  wire logic               abort,
    input  wire logic               fault,
    output logic                    gen_run,
    output logic [PULSE_W-1:0]      gen_period,
    output logic [PULSE_W-1:0]      gen_width,
    input  wire logic               gen_pulse,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    wdog_err,
    output logic                    cfg_err,
    output logic [CNT_W-1:0]        pulses_fired
);

    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] LOAD     = ST_LOAD;
    localparam logic [2:0] FIRE     = ST_FIRE;
    localparam logic [2:0] DRAIN    = ST_DRAIN;
    localparam logic [2:0] COOLDOWN = ST_COOLDOWN;

    localparam int LD_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] cool_cnt;
    logic [LD_W-1:0]  load_cnt;

    logic take, bad, accept, stop, final_edge;
    logic rise, wd_timeout;
    logic end_ok, end_abort, end_wdog;

    assign cfg.cfg_ready = (state == IDLE) & ~fault & ~abort;
    assign take          = cfg.cfg_valid & cfg.cfg_ready;
    assign bad           = cfg_bad(cfg.cfg_period, cfg.cfg_width);
    assign accept        = take & ~bad;
    assign stop          = (state != IDLE) & (abort | fault);
    assign final_edge    = rise & ((pulses_fired + CNT_W'(1)) == count_q);

    ppt_edge_counter #(
        .CNT_W       (CNT_W),
        .WDOG_MARGIN (WDOG_MARGIN)
    ) u_edge_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (accept),
        .fire         (state == FIRE),
        .gen_pulse    (gen_pulse),
        .period       (gen_period),
        .rise         (rise),
        .wd_timeout   (wd_timeout),
        .pulses_fired (pulses_fired)
    );

    always_comb begin
        state_nxt = state;
        end_ok    = 1'b0;
        end_abort = 1'b0;
        end_wdog  = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            end_abort = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cfg.cfg_count == '0)
                            end_ok = 1'b1;
                        else
                            state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt == '0)
                        state_nxt = FIRE;
                end
                FIRE: begin
                    if (wd_timeout) begin
                        state_nxt = IDLE;
                        end_wdog  = 1'b1;
                    end else if (final_edge) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    // Hold run until the last pulse has fully fallen
                    if (!gen_pulse)
                        state_nxt = COOLDOWN;
                end
                COOLDOWN: begin
                    if (cool_cnt == '0) begin
                        state_nxt = IDLE;
                        end_ok    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gen_run    <= 1'b0;
            gen_period <= GEN_PERIOD_RST;
            gen_width  <= GEN_WIDTH_RST;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            wdog_err   <= 1'b0;
            cfg_err    <= 1'b0;
            count_q    <= '0;
            cool_cnt   <= '0;
            load_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            gen_run <= (state_nxt == FIRE) || (state_nxt == DRAIN);
            busy    <= (state_nxt != IDLE);
            done    <= end_ok | end_abort | end_wdog;
            cfg_err <= take & bad;

            if (accept) begin
                aborted  <= 1'b0;
                wdog_err <= 1'b0;
            end
            if (end_abort || end_wdog)
                aborted <= 1'b1;
            if (end_wdog)
                wdog_err <= 1'b1;

            // Generator config only moves on accept, while gen_run is low
            if (accept && (cfg.cfg_count != '0)) begin
                gen_period <= cfg.cfg_period;
                gen_width  <= cfg.cfg_width;
                count_q    <= cfg.cfg_count;
                cool_cnt   <= cfg.cfg_cooldown;
                load_cnt   <= LD_W'(LOAD_CYC - 1);
            end else begin
                if ((state == LOAD) && (load_cnt != '0))
                    load_cnt <= load_cnt - LD_W'(1);
                if ((state == COOLDOWN) && (cool_cnt != '0))
                    cool_cnt <= cool_cnt - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppt_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppt_burst_scheduler
//  Brief    : Directed self-checking bench with a behavioural pulse generator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppt_burst_scheduler;
    import ppt_pkg::*;

    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               abort = 1'b0;
    logic               fault = 1'b0;
    logic               gen_run, gen_pulse;
    logic [PULSE_W-1:0] gen_period, gen_width;
    logic               busy, done, aborted, wdog_err, cfg_err;
    logic [CNT_W-1:0]   pulses_fired;

    int checks = 0;
    int errors = 0;

    ppt_burst_scheduler_if #(.CNT_W(CNT_W)) cfg_if ();

    ppt_burst_scheduler #(
        .CNT_W       (CNT_W),
        .LOAD_CYC    (2),
        .WDOG_MARGIN (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg_if),
        .abort        (abort),
        .fault        (fault),
        .gen_run      (gen_run),
        .gen_period   (gen_period),
        .gen_width    (gen_width),
        .gen_pulse    (gen_pulse),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .wdog_err     (wdog_err),
        .cfg_err      (cfg_err),
        .pulses_fired (pulses_fired)
    );

    always #5 clk = ~clk;

    // Pulse generator model: high for width cycles out of every period while run
    logic [PULSE_W-1:0] ph;
    logic               model_pulse;
    logic               force_low = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph          <= '0;
            model_pulse <= 1'b0;
        end else if (!gen_run) begin
            ph          <= '0;
            model_pulse <= 1'b0;
        end else begin
            model_pulse <= (ph < gen_width);
            ph          <= (ph >= gen_period - PULSE_W'(1)) ? '0 : ph + PULSE_W'(1);
        end
    end

    assign gen_pulse = force_low ? 1'b0 : model_pulse;

    int   rises = 0;
    logic mon_prev = 1'b0;
    always @(posedge clk) begin
        if (gen_pulse && !mon_prev)
            rises <= rises + 1;
        mon_prev <= gen_pulse;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns one negedge later with outputs settled
    task automatic send(input int per, input int wid, input int cnt, input int cool);
        cfg_if.cfg_period   = PULSE_W'(per);
        cfg_if.cfg_width    = PULSE_W'(wid);
        cfg_if.cfg_count    = CNT_W'(cnt);
        cfg_if.cfg_cooldown = CNT_W'(cool);
        cfg_if.cfg_valid    = 1'b1;
        @(negedge clk);
        cfg_if.cfg_valid    = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic reject_case(input string tag, input int per, input int wid);
        int err_seen, busy_seen, run_seen, done_seen;
        err_seen = 0; busy_seen = 0; run_seen = 0; done_seen = 0;
        send(per, wid, 4, 0);
        for (int i = 0; i < 4; i++) begin
            err_seen  += int'(cfg_err);
            busy_seen += int'(busy);
            run_seen  += int'(gen_run);
            done_seen += int'(done);
            @(negedge clk);
        end
        check({tag, "_cfg_err_strobes"}, err_seen, 1);
        check({tag, "_busy_never"}, busy_seen, 0);
        check({tag, "_run_never"}, run_seen, 0);
        check({tag, "_no_done"}, done_seen, 0);
    endtask

    initial begin
        int   fall_cyc, done_cyc, rises_at_fall, r0, run_cyc;
        logic prev_run, prev_pulse, pulse_before_fall;
        bit   seen;

        cfg_if.cfg_valid    = 1'b0;
        cfg_if.cfg_period   = '0;
        cfg_if.cfg_width    = '0;
        cfg_if.cfg_count    = '0;
        cfg_if.cfg_cooldown = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gen_run", gen_run, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_wdog_err", wdog_err, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pulses_fired", pulses_fired, 0);
        check("rst_gen_period", gen_period, 128);
        check("rst_gen_width", gen_width, 1);
        check("rst_cfg_ready", cfg_if.cfg_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal burst: period 10, width 3, count 4, cooldown 5
        r0 = rises;
        send(10, 3, 4, 5);
        check("burst_busy", busy, 1);
        check("burst_gen_period", gen_period, 10);
        check("burst_gen_width", gen_width, 3);
        prev_run = 1'b0; prev_pulse = 1'b0; pulse_before_fall = 1'b1;
        fall_cyc = -1; done_cyc = -1; rises_at_fall = -1;
        for (int i = 0; i < 200; i++) begin
            if (prev_run && !gen_run && fall_cyc < 0) begin
                fall_cyc          = i;
                pulse_before_fall = prev_pulse;
                rises_at_fall     = rises - r0;
            end
            if (done) begin
                done_cyc = i;
                break;
            end
            prev_run   = gen_run;
            prev_pulse = gen_pulse;
            @(negedge clk);
        end
        check("burst_done_seen", done_cyc >= 0, 1);
        check("burst_run_fell", fall_cyc >= 0, 1);
        check("burst_rises_at_run_fall", rises_at_fall, 4);
        check("burst_pulse_low_before_fall", pulse_before_fall, 0);
        check("burst_done_after_fall", done_cyc - fall_cyc, 6);
        check("burst_pulses_fired", pulses_fired, 4);
        check("burst_aborted", aborted, 0);
        check("burst_wdog_err", wdog_err, 0);
        @(negedge clk);
        check("burst_done_one_cycle", done, 0);
        check("burst_busy_cleared", busy, 0);
        repeat (30) @(negedge clk);
        check("burst_no_fifth_edge", rises - r0, 4);

        // Rejected commands
        reject_case("width_eq_period", 10, 10);
        reject_case("width_zero", 10, 0);
        check("reject_gen_period_kept", gen_period, 10);

        // Zero-count command
        send(10, 3, 0, 5);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_pulses_fired", pulses_fired, 0);
        run_cyc = 0;
        @(negedge clk);
        check("zero_done_strobe", done, 0);
        for (int i = 0; i < 8; i++) begin
            run_cyc += int'(gen_run);
            @(negedge clk);
        end
        check("zero_run_never", run_cyc, 0);

        // Abort after the third edge of a long burst
        send(10, 3, 100, 5);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pulses_fired == CNT_W'(3)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_third_edge_reached", seen, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_gen_run", gen_run, 0);
        check("abort_done", done, 1);
        check("abort_aborted", aborted, 1);
        check("abort_pulses_fired", pulses_fired, 3);
        check("abort_busy", busy, 0);
        send(10, 3, 2, 0);
        check("abort_followup_busy", busy, 1);
        check("abort_followup_aborted_clr", aborted, 0);
        wait_done(200, seen);
        check("abort_followup_done", seen, 1);
        check("abort_followup_pulses", pulses_fired, 2);
        check("abort_followup_aborted", aborted, 0);
        @(negedge clk);

        // Watchdog: generator output held low during FIRE
        force_low = 1'b1;
        send(20, 3, 5, 0);
        run_cyc = 0;
        seen    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            run_cyc += int'(gen_run);
            @(negedge clk);
        end
        check("wdog_done", seen, 1);
        check("wdog_aborted", aborted, 1);
        check("wdog_wdog_err", wdog_err, 1);
        check("wdog_gen_run", gen_run, 0);
        check("wdog_run_cycles", run_cyc, 25);
        check("wdog_pulses_fired", pulses_fired, 0);
        force_low = 1'b0;
        @(negedge clk);

        // Fault during cooldown, then lockout until it drops
        send(10, 3, 1, 20);
        prev_run = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (prev_run && !gen_run) begin
                seen = 1'b1;
                break;
            end
            prev_run = gen_run;
            @(negedge clk);
        end
        check("fault_reached_cooldown", seen, 1);
        check("fault_wdog_cleared", wdog_err, 0);
        repeat (2) @(negedge clk);
        fault = 1'b1;
        @(negedge clk);
        check("fault_busy", busy, 0);
        check("fault_done", done, 1);
        check("fault_aborted", aborted, 1);
        check("fault_cfg_ready", cfg_if.cfg_ready, 0);
        cfg_if.cfg_period   = PULSE_W'(10);
        cfg_if.cfg_width    = PULSE_W'(3);
        cfg_if.cfg_count    = CNT_W'(1);
        cfg_if.cfg_cooldown = CNT_W'(0);
        cfg_if.cfg_valid    = 1'b1;
        run_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_cyc += int'(busy) + int'(cfg_err);
        end
        cfg_if.cfg_valid = 1'b0;
        check("fault_cmd_ignored", run_cyc, 0);
        fault = 1'b0;
        #1;
        check("fault_release_ready", cfg_if.cfg_ready, 1);
        @(negedge clk);
        send(10, 3, 1, 0);
        check("fault_followup_busy", busy, 1);
        wait_done(200, seen);
        check("fault_followup_done", seen, 1);
        check("fault_followup_aborted", aborted, 0);
        check("fault_followup_pulses", pulses_fired, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppt_burst_scheduler.md
Name: ppt_burst_scheduler

Overview:
Sequences the thruster pulse generator through complete firing bursts. Accepts one burst command at a time (period, width, pulse count, cooldown), loads the generator, holds run until exactly N pulses have been emitted, then enforces a cooldown before the next command. Sits between the host/register interface and pulse_generator, and counts the generator's pulse_out via gen_pulse. Provides abort, fault lockout and a missing-pulse watchdog.

Parameters:
CNT_W, 16, width of pulse count, cooldown counter and pulses_fired
LOAD_CYC, 2, cycles gen_run is held low with new config before firing (min 1)
WDOG_MARGIN, 4, extra cycles beyond cfg_period allowed between pulse edges

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cfg_valid  in  1  burst command valid
cfg_ready  out  1  scheduler can accept a command
cfg_period  in  14  pulse period in clk cycles
cfg_width  in  14  pulse width in clk cycles
cfg_count  in  CNT_W  pulses in the burst
cfg_cooldown  in  CNT_W  idle cycles after the burst
abort  in  1  stop the burst immediately
fault  in  1  level; acts as abort and blocks acceptance while high
gen_run  out  1  to pulse_generator run
gen_period  out  14  to pulse_generator pulse_period
gen_width  out  14  to pulse_generator pulse_width
gen_pulse  in  1  from pulse_generator pulse_out
busy  out  1  high in every state except IDLE
done  out  1  one-cycle strobe at end of every accepted burst
aborted  out  1  qualifies done: burst ended by abort, fault or watchdog
wdog_err  out  1  qualifies done: burst ended by watchdog
cfg_err  out  1  one-cycle strobe: command rejected
pulses_fired  out  CNT_W  rising edges counted in the current or last burst

Behaviour:
- Reset values:
  - gen_run, busy, done, aborted, wdog_err, cfg_err = 0; pulses_fired = 0.
  - gen_period = 128; gen_width = 1.
  - cfg_ready = 1 when fault = 0; state = IDLE.
- All outputs are registered except cfg_ready. cfg_ready = (state == IDLE) & ~fault & ~abort.
- States: IDLE, LOAD, FIRE, DRAIN, COOLDOWN.
- IDLE: accept on cfg_valid & cfg_ready.
  - Reject (cfg_err = 1 next cycle, stay IDLE, no done) if cfg_width == 0 or cfg_width >= cfg_period.
  - Accept with cfg_count == 0: done = 1 next cycle, gen_run never asserted, pulses_fired = 0.
  - Otherwise latch all cfg fields, clear pulses_fired, aborted and wdog_err, drive gen_period/gen_width, and go to LOAD.
- LOAD: gen_run = 0 for LOAD_CYC cycles so the generator captures the config, then go to FIRE.
- FIRE: gen_run = 1.
  - Rising edge of gen_pulse (registered previous value) increments pulses_fired.
  - The edge that makes pulses_fired == count moves to DRAIN.
- DRAIN: gen_run stays 1 until gen_pulse is sampled 0, so the last pulse is full width. Then gen_run = 0 and go to COOLDOWN.
- COOLDOWN: gen_run = 0 for cfg_cooldown cycles. Then done = 1 for one cycle and go to IDLE. With cooldown == 0, done follows on the next cycle.
- Watchdog (FIRE only):
  - A cycle counter resets on each rising edge and on entry to FIRE.
  - If it reaches cfg_period + WDOG_MARGIN, go to IDLE with gen_run = 0 and done = aborted = wdog_err = 1.
  - The compare is performed at 15 bits; no wrap.
- Abort/fault in LOAD, FIRE, DRAIN or COOLDOWN: next cycle gen_run = 0, state = IDLE, done = aborted = 1. A truncated pulse is permitted.
- Simultaneous events:
  - abort and the final edge in the same cycle: abort wins, but the edge is still counted.
  - abort in IDLE: command not accepted that cycle.
  - fault held: stay IDLE with cfg_ready = 0.
- pulses_fired saturates at all-ones and holds its value after done until the next accept.
- gen_period/gen_width change only on accept; they are never altered while gen_run = 1.
- Reset mid-burst returns everything to reset values immediately (asynchronous).

Decomposition:
- Package ppt_pkg holds:
  - state enum (IDLE/LOAD/FIRE/DRAIN/COOLDOWN);
  - PULSE_W = 14;
  - reset constants GEN_PERIOD_RST = 128 and GEN_WIDTH_RST = 1, shared with pulse_generator.
- One sub-module is natural: ppt_edge_counter. It covers gen_pulse registering, rising-edge detection, saturating pulses_fired and the watchdog counter.
- The FSM stays in ppt_burst_scheduler.

Test Plan:
- Bench instantiates pulse_generator driven by gen_* outputs. Command period = 10, width = 3, count = 4, cooldown = 5:
  - exactly 4 gen_pulse rising edges, with no 5th;
  - gen_run drops only after the 4th pulse falls;
  - done 6 cycles after gen_run falls (1 DRAIN exit + 5 cooldown);
  - pulses_fired = 4, aborted = 0.
- Command width = 10, period = 10, and separately width = 0: cfg_err strobes, busy stays 0, gen_run never rises.
- Command count = 0: done next cycle, gen_run stays 0, pulses_fired = 0.
- Burst count = 100, abort asserted after the 3rd edge: gen_run = 0 the next cycle, done & aborted, pulses_fired = 3. A follow-up command is accepted.
- Bench forces gen_pulse = 0 during FIRE with period = 20: watchdog fires after 24 cycles without an edge, giving done, aborted and wdog_err, with gen_run low.
- fault high during COOLDOWN: IDLE with aborted; cfg_ready stays 0 and cfg_valid is ignored until fault drops, then the next command is accepted.
